mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 34 +++
 rtl/mem_arbiter.sv | 128 ++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the instruction/data caches, the arbiter and the RAM.
// The arbiter connects through the slave modport; the cache/RAM side uses master.
interface mem_arbiter_if;
    // instruction cache side
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    // data cache side
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    // RAM side
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic        ram_err;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, ram_err
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, ram_err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-client RAM arbiter: data requests win by default, but an instruction
// request that has watched STARVE_MAX consecutive data grants is served next.
// Completion is signalled combinationally on the RAM ACCESS cycle.
module mem_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic         CLK,
    input  logic         RST,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, IGRANT, DREAD, DWRITE} state_t;

    localparam logic [1:0]  RAM_ACCESS = 2'd2;
    localparam logic [1:0]  RAM_ERROR  = 2'd3;
    localparam int unsigned CW         = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    state_t        state_q, state_d;
    logic [CW-1:0] starve_q, starve_d;
    logic          ram_err_q, ram_err_d;
    logic          ren_q, ren_d;
    logic          wen_q, wen_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   store_q, store_d;

    logic [CW-1:0] starve_inc;
    logic          owner_req;
    logic          i_done, d_rd_done, d_wr_done;

    // Next-state: arbitration in IDLE, hold/retry/complete/abort in a grant.
    always_comb begin
        state_d   = state_q;
        starve_d  = starve_q;
        ram_err_d = ram_err_q;
        ren_d     = ren_q;
        wen_d     = wen_q;
        addr_d    = addr_q;
        store_d   = store_q;
        owner_req = 1'b0;
        starve_inc = (starve_q == STARVE_LIM) ? starve_q : starve_q + 1'b1;

        case (state_q)
            IDLE: begin
                ren_d = 1'b0;
                wen_d = 1'b0;
                if (bus.iREN && (starve_q == STARVE_LIM)) begin
                    state_d  = IGRANT;
                    ren_d    = 1'b1;
                    addr_d   = bus.iaddr;
                    starve_d = '0;
                end else if (bus.dWEN) begin
                    // a simultaneous dREN is deliberately ignored: write wins
                    state_d  = DWRITE;
                    wen_d    = 1'b1;
                    addr_d   = bus.daddr;
                    store_d  = bus.dstore;
                    starve_d = bus.iREN ? starve_inc : '0;
                end else if (bus.dREN) begin
                    state_d  = DREAD;
                    ren_d    = 1'b1;
                    addr_d   = bus.daddr;
                    starve_d = bus.iREN ? starve_inc : '0;
                end else if (bus.iREN) begin
                    state_d  = IGRANT;
                    ren_d    = 1'b1;
                    addr_d   = bus.iaddr;
                    starve_d = '0;
                end else begin
                    starve_d = '0;
                end
            end
            default: begin
                case (state_q)
                    IGRANT:  owner_req = bus.iREN;
                    DREAD:   owner_req = bus.dREN;
                    default: owner_req = bus.dWEN;
                endcase
                if (bus.ramstate == RAM_ERROR) begin
                    ram_err_d = 1'b1;
                end
                // owner gone or access done: back to IDLE for a fresh arbitration
                if (!owner_req || (bus.ramstate == RAM_ACCESS)) begin
                    state_d = IDLE;
                    ren_d   = 1'b0;
                    wen_d   = 1'b0;
                end
            end
        endcase
    end

    // State and registered RAM-side outputs, asynchronously cleared.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            starve_q  <= '0;
            ram_err_q <= 1'b0;
            ren_q     <= 1'b0;
            wen_q     <= 1'b0;
            addr_q    <= '0;
            store_q   <= '0;
        end else begin
            state_q   <= state_d;
            starve_q  <= starve_d;
            ram_err_q <= ram_err_d;
            ren_q     <= ren_d;
            wen_q     <= wen_d;
            addr_q    <= addr_d;
            store_q   <= store_d;
        end
    end

    // Completion strobes: same-cycle on ACCESS, only while the owner still requests.
    always_comb begin
        i_done    = (state_q == IGRANT) && bus.iREN && (bus.ramstate == RAM_ACCESS);
        d_rd_done = (state_q == DREAD)  && bus.dREN && (bus.ramstate == RAM_ACCESS);
        d_wr_done = (state_q == DWRITE) && bus.dWEN && (bus.ramstate == RAM_ACCESS);
        bus.iwait = !i_done;
        bus.iload = i_done ? bus.ramload : '0;
        bus.dwait = !(d_rd_done || d_wr_done);
        bus.dload = d_rd_done ? bus.ramload : '0;
    end

    assign bus.ramREN   = ren_q;
    assign bus.ramWEN   = wen_q;
    assign bus.ramaddr  = addr_q;
    assign bus.ramstore = store_q;
    assign bus.ram_err  = ram_err_q;
endmodule
